// File: rtl/multu_seq_ctrl.sv
// Iterative shift-add MULTU sequencer that owns the HI/LO registers.
// Asserts stall while a multiply is in flight and the current instruction needs HI/LO or the multiplier.
module multu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             mf_req_i,
    input  logic             hi_lo_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] mf_data_o,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic [WIDTH:0]       sum;

    // The carry out of the partial-product add is kept and shifted into the top of prod.
    assign sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d = op_a_i;
                    prod_d  = {{WIDTH{1'b0}}, op_b_i};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                prod_d = {sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                hi_d    = prod_q[2*WIDTH-1:WIDTH];
                lo_d    = prod_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A held multu or mf read only waits while the sequencer is not idle.
    assign busy_o    = (state_q != S_IDLE);
    assign stall_o   = busy_o & (start_i | mf_req_i);
    assign done_o    = done_q;
    assign mf_data_o = hi_lo_i ? lo_q : hi_q;

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Directed bench for multu_seq_ctrl: 32-bit instance for the main sequence, 8-bit instance for the small width.
module tb_multu_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start, mf_req, hi_lo;
    logic [31:0] op_a, op_b, mf_data;
    logic        stall, busy, done;

    logic        start8, mf_req8, hi_lo8;
    logic [7:0]  op_a8, op_b8, mf_data8;
    logic        stall8, busy8, done8;

    int checks = 0;
    int errors = 0;
    int n;
    int pulses;

    multu_seq_ctrl #(.WIDTH(32)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .mf_req_i(mf_req), .hi_lo_i(hi_lo),
        .op_a_i(op_a), .op_b_i(op_b), .mf_data_o(mf_data), .stall_o(stall),
        .busy_o(busy), .done_o(done)
    );

    multu_seq_ctrl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .reset_i(reset), .start_i(start8), .mf_req_i(mf_req8), .hi_lo_i(hi_lo8),
        .op_a_i(op_a8), .op_b_i(op_b8), .mf_data_o(mf_data8), .stall_o(stall8),
        .busy_o(busy8), .done_o(done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic read_hi(output logic [31:0] v);
        hi_lo = 1'b0;
        #1;
        v = mf_data;
    endtask

    task automatic read_lo(output logic [31:0] v);
        hi_lo = 1'b1;
        #1;
        v = mf_data;
    endtask

    // Counts observation points with busy high, bounded so a stuck DUT still reaches the summary.
    task automatic wait_busy(output int cnt, output int dpulses);
        cnt = 0;
        dpulses = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (done) dpulses++;
            tick();
        end
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1;
        start = 0; mf_req = 0; hi_lo = 0; op_a = 0; op_b = 0;
        start8 = 0; mf_req8 = 0; hi_lo8 = 0; op_a8 = 0; op_b8 = 0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_stall", {63'b0, stall}, 64'd0);
        read_hi(v); check("reset_hi", {32'b0, v}, 64'd0);
        read_lo(v); check("reset_lo", {32'b0, v}, 64'd0);

        // 1: 30*31, busy for 33 cycles, done pulses once
        start = 1; op_a = 32'd30; op_b = 32'd31;
        #1;
        check("t1_idle_stall", {63'b0, stall}, 64'd0);
        tick();
        start = 0;
        wait_busy(n, pulses);
        check("t1_busy_cycles", 64'(n), 64'd33);
        check("t1_done_early", 64'(pulses), 64'd0);
        check("t1_done_pulse", {63'b0, done}, 64'd1);
        read_lo(v); check("t1_lo", {32'b0, v}, 64'd930);
        read_hi(v); check("t1_hi", {32'b0, v}, 64'd0);
        tick();
        check("t1_done_clear", {63'b0, done}, 64'd0);
        $display("t1 30*31 busy=%0d cycles", n);

        // 2: all-ones operands exercise the carry
        start = 1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        tick();
        start = 0;
        wait_busy(n, pulses);
        read_hi(v); check("t2_hi", {32'b0, v}, 64'hFFFF_FFFE);
        read_lo(v); check("t2_lo", {32'b0, v}, 64'h0000_0001);
        $display("t2 ffffffff*ffffffff busy=%0d cycles", n);

        // 3: held mfhi/mflo stalls until the result lands
        start = 1; op_a = 32'd30; op_b = 32'd31;
        tick();
        start = 0; mf_req = 1; hi_lo = 1;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            tick();
        end
        check("t3_stall_cycles", 64'(n), 64'd33);
        check("t3_mf_data", {32'b0, mf_data}, 64'd930);
        mf_req = 0;
        tick();
        $display("t3 held mf_req stall=%0d cycles", n);

        // 4: back-to-back multu via hold
        start = 1; op_a = 32'd30; op_b = 32'd31;
        tick();
        op_a = 32'd7; op_b = 32'd6;
        #1;
        n = 0;
        while (stall && n < 200) begin
            n++;
            tick();
        end
        check("t4_stall_cycles", 64'(n), 64'd33);
        check("t4_busy_released", {63'b0, busy}, 64'd0);
        tick();
        start = 0;
        check("t4_second_accept", {63'b0, busy}, 64'd1);
        wait_busy(n, pulses);
        read_lo(v); check("t4_lo", {32'b0, v}, 64'd42);
        read_hi(v); check("t4_hi", {32'b0, v}, 64'd0);
        $display("t4 back-to-back 7*6 busy=%0d cycles", n);

        // start with mf_req in IDLE: old value read, no stall, multiply accepted
        start = 1; mf_req = 1; op_a = 32'd3; op_b = 32'd4;
        read_lo(v);
        check("idle_both_stall", {63'b0, stall}, 64'd0);
        check("idle_both_old_lo", {32'b0, v}, 64'd42);
        tick();
        start = 0; mf_req = 0;
        check("idle_both_accept", {63'b0, busy}, 64'd1);
        wait_busy(n, pulses);
        read_lo(v); check("idle_both_lo", {32'b0, v}, 64'd12);
        $display("idle start+mf_req 3*4 busy=%0d cycles", n);

        // pure read in IDLE changes nothing
        mf_req = 1;
        tick();
        check("pure_read_busy", {63'b0, busy}, 64'd0);
        check("pure_read_stall", {63'b0, stall}, 64'd0);
        mf_req = 0;

        // 5: reset while RUN with cnt==10 aborts the multiply
        start = 1; op_a = 32'd5; op_b = 32'd9;
        tick();
        start = 0;
        repeat (10) tick();
        check("t5_running", {63'b0, busy}, 64'd1);
        reset = 1;
        tick();
        check("t5_busy", {63'b0, busy}, 64'd0);
        check("t5_done", {63'b0, done}, 64'd0);
        read_hi(v); check("t5_hi", {32'b0, v}, 64'd0);
        read_lo(v); check("t5_lo", {32'b0, v}, 64'd0);
        reset = 0;
        tick();
        check("t5_no_done", {63'b0, done}, 64'd0);
        check("t5_idle", {63'b0, busy}, 64'd0);
        $display("t5 reset abort at cnt 10");

        // 6: WIDTH=8, 0xFF*0xFF
        start8 = 1; op_a8 = 8'hFF; op_b8 = 8'hFF;
        tick();
        start8 = 0;
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            tick();
        end
        check("t6_busy_cycles", 64'(n), 64'd9);
        check("t6_done", {63'b0, done8}, 64'd1);
        hi_lo8 = 0; #1;
        check("t6_hi", {56'b0, mf_data8}, 64'hFE);
        hi_lo8 = 1; #1;
        check("t6_lo", {56'b0, mf_data8}, 64'h01);
        $display("t6 width8 ff*ff busy=%0d cycles", n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
